rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the single register-file write port (we3/wa3/wd3) between the CPU datapath and
//  NREQ input-port peripherals. The CPU has priority; idle CPU cycles go round-robin to peripherals.
//  A starvation counter forces a one-cycle CPU stall (PC enable low) to guarantee a peripheral slot.
//  Sits between the control unit/datapath write signals and the 16x8 register file.
// PARAMETERS
//  NREQ      4   number of peripheral requesters (2..8)
//  MAX_WAIT  4   consecutive ungranted cycles with a pending request before forcing (>=1)
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  reset      in   1        synchronous, active-high reset
//  cpu_we     in   1        CPU register write enable for this cycle
//  cpu_wa     in   4        CPU destination register
//  cpu_wd     in   8        CPU write data
//  io_req     in   NREQ     peripheral i requests a write; held until io_gnt[i]
//  io_wa      in   4*NREQ   dest reg of peripheral i in bits [4i+3:4i]
//  io_wd      in   8*NREQ   data of peripheral i in bits [8i+7:8i]
//  io_gnt     out  NREQ     one-hot; write of peripheral i happens at this clock edge
//  stall      out  1        to CPU: hold PC (enable=0), discard CPU write this cycle
//  we3        out  1        to regfile write enable
//  wa3        out  4        to regfile write address
//  wd3        out  8        to regfile write data
// BEHAVIOUR
//  - State: rr_ptr (clog2(NREQ) bits), wait_cnt (0..MAX_WAIT, saturating), force_q (NORMAL=0/FORCE=1).
//  - Reset (sync): rr_ptr=0, wait_cnt=0, force_q=0. While reset is high: we3=0, io_gnt=0, stall=0,
//    wa3=0, wd3=0, regardless of inputs.
//  - Outputs are combinational from inputs and state (zero latency); writes land at the same edge.
//  - stall = force_q (Moore, exactly one cycle per force event).
//  - Winner W = first i with io_req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//  - NORMAL, cpu_we=1: we3=1, wa3=cpu_wa, wd3=cpu_wd, io_gnt=0.
//  - NORMAL, cpu_we=0, |io_req: we3=1, wa3/wd3 from W, io_gnt[W]=1, rr_ptr<=(W+1) mod NREQ.
//  - NORMAL, cpu_we=0, no req: we3=0, wa3=0, wd3=0, io_gnt=0.
//  - FORCE: CPU write ignored; if |io_req, grant W exactly as above; else we3=0, io_gnt=0.
//    Always returns to NORMAL next cycle; wait_cnt<=0.
//  - wait_cnt (in NORMAL): cleared on any io grant or when io_req==0; else +1 (saturates at MAX_WAIT).
//    force_q<=1 when the next wait_cnt equals MAX_WAIT; wait_cnt is cleared in the FORCE cycle.
//  - Write to register 0 is forwarded unchanged (the register file reads r0 as 0).
//  - Peripheral must hold io_wa/io_wd stable while io_req=1; dropping io_req before grant is legal.
//  - rr_ptr advances only on a peripheral grant; CPU writes never move it.
// TESTING
//  1. Reset; cpu_we=1, cpu_wa=3, cpu_wd=8'h5A, io_req=0 -> we3=1, wa3=3, wd3=8'h5A, io_gnt=0, stall=0.
//  2. cpu_we=0, io_req=4'b1010 held 3 cycles from reset -> io_gnt=0010, then 1000, then 0010.
//  3. MAX_WAIT=4, cpu_we=1 constant, io_req=0001 (wa=5, wd=8'h33) -> cycles 1-4: io_gnt=0, stall=0;
//     cycle 5: stall=1, io_gnt=0001, we3=1, wa3=5, wd3=8'h33; cycle 6: stall=0, CPU owns the port again.
//  4. As in 3, but io_req drops to 0 in the FORCE cycle -> stall=1, we3=0, io_gnt=0; next cycle NORMAL.
//  5. Assert reset during the FORCE cycle -> we3=0, stall=0, io_gnt=0; after release, with cpu_we=0
//     and io_req=1111, the grant is io_gnt=0001 (rr_ptr=0) and no stall for 4 cycles.
//  6. cpu_we=0, io_req=1000 then 0001 on the next cycle -> grants 1000, then 0001; wait_cnt stays 0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the CPU has priority, and idle CPU cycles go round-robin to
// peripherals. A starvation counter forces a one-cycle CPU stall so a waiting peripheral gets a slot.
module rf_write_arbiter #(
   parameter int NREQ     = 4,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_we,
   input  logic [3:0]        cpu_wa,
   input  logic [7:0]        cpu_wd,
   input  logic [NREQ-1:0]   io_req,
   input  logic [4*NREQ-1:0] io_wa,
   input  logic [8*NREQ-1:0] io_wd,
   output logic [NREQ-1:0]   io_gnt,
   output logic              stall,
   output logic              we3,
   output logic [3:0]        wa3,
   output logic [7:0]        wd3
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} mode_e;

   mode_e            force_q, force_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] next_ptr;
   logic             grant;

   // Round-robin scan starting at rr_ptr_q; the first requester found wins.
   always_comb begin : p_scan
      int   idx;
      logic found;
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      idx      = 0;
      found    = 1'b0;
      win_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NREQ;
         if (!found && io_req[idx]) begin
            found   = 1'b1;
            win_idx = PTR_W'(idx);
         end
      end
      next_ptr = PTR_W'((int'(win_idx) + 1) % NREQ);
   end

   always_comb begin
      we3    = 1'b0;
      wa3    = '0;
      wd3    = '0;
      io_gnt = '0;
      stall  = 1'b0;
      grant  = 1'b0;
      if (!reset) begin
         stall = (force_q == FORCE);
         if (force_q == NORMAL && cpu_we) begin
            we3 = 1'b1;
            wa3 = cpu_wa;
            wd3 = cpu_wd;
         end else if (|io_req) begin
            grant           = 1'b1;
            we3             = 1'b1;
            wa3             = io_wa[4*win_idx +: 4];
            wd3             = io_wd[8*win_idx +: 8];
            io_gnt[win_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d   = grant ? next_ptr : rr_ptr_q;
      wait_cnt_d = '0;
      force_d    = NORMAL;
      if (force_q == NORMAL) begin
         if (grant || io_req == '0)
            wait_cnt_d = '0;
         else if (wait_cnt_q != MAX_CNT)
            wait_cnt_d = wait_cnt_q + 1'b1;
         else
            wait_cnt_d = wait_cnt_q;
         // Arm the stall so the slot is guaranteed on the cycle the count reaches its limit.
         force_d = (wait_cnt_d == MAX_CNT) ? FORCE : NORMAL;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         wait_cnt_q <= '0;
         force_q    <= NORMAL;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         wait_cnt_q <= wait_cnt_d;
         force_q    <= force_d;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (NREQ=4, MAX_WAIT=4); outputs are sampled on the falling edge.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_we;
   logic [3:0]  cpu_wa;
   logic [7:0]  cpu_wd;
   logic [3:0]  io_req;
   logic [15:0] io_wa;
   logic [31:0] io_wd;
   logic [3:0]  io_gnt;
   logic        stall;
   logic        we3;
   logic [3:0]  wa3;
   logic [7:0]  wd3;

   int tests_run    = 0;
   int tests_failed = 0;

   rf_write_arbiter #(.NREQ(4), .MAX_WAIT(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .cpu_we (cpu_we),
      .cpu_wa (cpu_wa),
      .cpu_wd (cpu_wd),
      .io_req (io_req),
      .io_wa  (io_wa),
      .io_wd  (io_wd),
      .io_gnt (io_gnt),
      .stall  (stall),
      .we3    (we3),
      .wa3    (wa3),
      .wd3    (wd3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Compare every output at the falling edge of the current cycle.
   task automatic expect_out(input string tag, input logic e_we, input logic [3:0] e_wa,
                             input logic [7:0] e_wd, input logic [3:0] e_gnt, input logic e_stall);
      @(negedge clk);
      check({tag, ".we3"},   32'(we3),    32'(e_we));
      check({tag, ".wa3"},   32'(wa3),    32'(e_wa));
      check({tag, ".wd3"},   32'(wd3),    32'(e_wd));
      check({tag, ".gnt"},   32'(io_gnt), 32'(e_gnt));
      check({tag, ".stall"}, 32'(stall),  32'(e_stall));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      cpu_we = 1'b1;
      cpu_wa = 4'd3;
      cpu_wd = 8'h5A;
      io_req = 4'b1111;
      io_wa  = {4'hC, 4'h9, 4'h2, 4'h5};
      io_wd  = {8'hD4, 8'hC3, 8'hB2, 8'h33};

      // Reset dominates active inputs.
      expect_out("rst", 1'b0, 4'h0, 8'h00, 4'b0000, 1'b0);
      tick();
      reset = 1'b0;

      // 1: CPU write passes straight through.
      io_req = 4'b0000;
      expect_out("t1", 1'b1, 4'h3, 8'h5A, 4'b0000, 1'b0);
      tick();

      // 2: round-robin between peripherals 1 and 3.
      do_reset();
      cpu_we = 1'b0;
      io_req = 4'b1010;
      expect_out("t2.c1", 1'b1, 4'h2, 8'hB2, 4'b0010, 1'b0);
      tick();
      expect_out("t2.c2", 1'b1, 4'hC, 8'hD4, 4'b1000, 1'b0);
      tick();
      expect_out("t2.c3", 1'b1, 4'h2, 8'hB2, 4'b0010, 1'b0);
      tick();

      // 3: starvation forces a stall on cycle 5.
      do_reset();
      cpu_we = 1'b1;
      io_req = 4'b0001;
      for (int c = 1; c <= 4; c++) begin
         expect_out($sformatf("t3.c%0d", c), 1'b1, 4'h3, 8'h5A, 4'b0000, 1'b0);
         tick();
      end
      expect_out("t3.c5", 1'b1, 4'h5, 8'h33, 4'b0001, 1'b1);
      tick();
      io_req = 4'b0000;
      expect_out("t3.c6", 1'b1, 4'h3, 8'h5A, 4'b0000, 1'b0);
      tick();

      // 4: request withdrawn in the forced cycle.
      do_reset();
      io_req = 4'b0001;
      for (int c = 1; c <= 4; c++) tick();
      io_req = 4'b0000;
      expect_out("t4.c5", 1'b0, 4'h0, 8'h00, 4'b0000, 1'b1);
      tick();
      expect_out("t4.c6", 1'b1, 4'h3, 8'h5A, 4'b0000, 1'b0);
      tick();

      // 5: reset during the forced cycle, then full round-robin from pointer 0.
      do_reset();
      io_req = 4'b0001;
      for (int c = 1; c <= 4; c++) tick();
      reset = 1'b1;
      expect_out("t5.rst", 1'b0, 4'h0, 8'h00, 4'b0000, 1'b0);
      tick();
      reset  = 1'b0;
      cpu_we = 1'b0;
      io_req = 4'b1111;
      expect_out("t5.g0", 1'b1, 4'h5, 8'h33, 4'b0001, 1'b0);
      tick();
      expect_out("t5.g1", 1'b1, 4'h2, 8'hB2, 4'b0010, 1'b0);
      tick();
      expect_out("t5.g2", 1'b1, 4'h9, 8'hC3, 4'b0100, 1'b0);
      tick();
      expect_out("t5.g3", 1'b1, 4'hC, 8'hD4, 4'b1000, 1'b0);
      tick();

      // 6: grants to 3 then 0, counter stays clear; then a fresh 4-cycle starvation run.
      do_reset();
      io_req = 4'b1000;
      expect_out("t6.c1", 1'b1, 4'hC, 8'hD4, 4'b1000, 1'b0);
      tick();
      io_req = 4'b0001;
      expect_out("t6.c2", 1'b1, 4'h5, 8'h33, 4'b0001, 1'b0);
      tick();
      io_req = 4'b0000;
      expect_out("t6.idle", 1'b0, 4'h0, 8'h00, 4'b0000, 1'b0);
      tick();
      cpu_we = 1'b1;
      io_req = 4'b0010;
      for (int c = 1; c <= 4; c++) begin
         expect_out($sformatf("t6.w%0d", c), 1'b1, 4'h3, 8'h5A, 4'b0000, 1'b0);
         tick();
      end
      expect_out("t6.force", 1'b1, 4'h2, 8'hB2, 4'b0010, 1'b1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
